booth_mult_seq: RTL



---
 rtl/mult_pkg.sv | 28 ++
 rtl/booth_recode.sv | 48 ++++
 rtl/booth_mult_seq.sv | 91 +++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and sizing for the sequential Booth multiplier.
//   state_t    : controller states (IDLE/RUN/DONE)
//   boothSel_t : recoded partial-product select (0, +A, -A, +2A, -2A)
//   MULT_W     : operand/result width
//   PROD_W     : Booth product register width (accumulator | multiplier | extra bit)
//   STEPS      : number of RUN edges per operation
// Build option: MULT_RADIX4_EN selects radix-4 recoding (2 bits per step).
package mult_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [2:0] {ZERO, PA, MA, P2A, M2A} boothSel_t;

    localparam int MULT_W = 32;
`ifdef MULT_RADIX4_EN
    localparam int PROD_W  = 66;
    localparam int STEPS   = 16;
    localparam int SHIFT   = 2;
    localparam int GROUP_W = 3;
`else
    localparam int PROD_W  = 65;
    localparam int STEPS   = 32;
    localparam int SHIFT   = 1;
    localparam int GROUP_W = 2;
`endif
    // Adder width: accumulator field sign-extended by one bit so that the
    // -A (and -2A) path survives A = 0x80000000.
    localparam int ACC_W = PROD_W - MULT_W;
    localparam int CNT_W = $clog2(STEPS);
endpackage

// File: rtl/booth_recode.sv
// booth_recode: combinational Booth recoder plus addend mux.
//   boothBits    in  : low bits of P (P[1:0], or P[2:0] for radix-4)
//   multiplicand in  : latched multiplicand A
//   sel          out : recoded select
//   addend       out : selected addend, sign-extended to the adder width
// Build option: MULT_RADIX4_EN (triple recoding, 0/+-A/+-2A).
module booth_recode
    import mult_pkg::*;
(
    input  logic [GROUP_W-1:0] boothBits,
    input  logic [MULT_W-1:0]  multiplicand,
    output boothSel_t          sel,
    output logic [ACC_W-1:0]   addend
);
    logic [ACC_W-1:0] aExt;

    assign aExt = {{(ACC_W-MULT_W){multiplicand[MULT_W-1]}}, multiplicand};

    always_comb begin
        sel = ZERO;
`ifdef MULT_RADIX4_EN
        case (boothBits)
            3'b001, 3'b010: sel = PA;
            3'b011:         sel = P2A;
            3'b100:         sel = M2A;
            3'b101, 3'b110: sel = MA;
            default:        sel = ZERO;
        endcase
`else
        case (boothBits)
            2'b01:   sel = PA;
            2'b10:   sel = MA;
            default: sel = ZERO;
        endcase
`endif
    end

    always_comb begin
        addend = '0;
        case (sel)
            PA:      addend = aExt;
            MA:      addend = -aExt;
            P2A:     addend = aExt << 1;
            M2A:     addend = -(aExt << 1);
            default: addend = '0;
        endcase
    end
endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential signed Booth multiplier (low 32-bit result +
// signed-overflow flag). A start pulse launches STEPS add/sub-and-shift
// edges; a one-cycle ready pulse follows the last one.
//   clock, reset_n  : rising-edge clock, async active-low reset
//   ctrl_MULT       : start (also aborts/restarts an operation in flight)
//   data_operandA/B : multiplicand / multiplier, sampled on the start edge
//   data_result     : P[32:1]
//   data_exception  : product does not fit signed 32 bits
//   data_resultRDY  : high for the single DONE cycle
// Build option: MULT_RADIX4_EN (radix-4, 16 steps, 17-cycle latency).
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    state_t                 state, nextState;
    logic [CNT_W-1:0]       count;
    logic [PROD_W-1:0]      p, pNext;
    logic [MULT_W-1:0]      a;
    logic                   exc, ovf, lastStep;
    boothSel_t              sel;
    logic [ACC_W-1:0]       addend, accExt, sum;
    logic [ACC_W+MULT_W:0]  wide;

    booth_recode uRecode (
        .boothBits    (p[GROUP_W-1:0]),
        .multiplicand (a),
        .sel          (sel),
        .addend       (addend)
    );

    assign lastStep = (state == RUN) && (count == CNT_W'(STEPS-1));

    // Accumulator sign-extended one bit, add/sub, then arithmetic shift of
    // the whole {sum, multiplier, extra} word; the shift drops the consumed
    // Booth bits and the cast keeps the sign-extended top of the register.
    assign accExt = {p[PROD_W-1], p[PROD_W-1:MULT_W+1]};
    assign sum    = accExt + addend;
    assign wide   = {sum, p[MULT_W:0]};
    assign pNext  = PROD_W'($signed(wide) >>> SHIFT);

    // Product is pNext[64:1]; it fits signed 32 bits iff bits 64..32 agree.
    assign ovf = !((&pNext[64:32]) || !(|pNext[64:32]));

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (ctrl_MULT) nextState = RUN;
            RUN:     if (ctrl_MULT) nextState = RUN;
                     else if (lastStep) nextState = DONE;
            DONE:    nextState = ctrl_MULT ? RUN : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nextState;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            p     <= '0;
            a     <= '0;
            exc   <= 1'b0;
        end else if (ctrl_MULT) begin
            // Start or abort-and-restart from any state.
            a     <= data_operandA;
            p     <= {{(PROD_W-MULT_W-1){1'b0}}, data_operandB, 1'b0};
            count <= '0;
        end else if (state == RUN) begin
            p     <= pNext;
            count <= count + 1'b1;
            if (lastStep) exc <= ovf;
        end
    end

    assign data_result    = p[MULT_W:1];
    assign data_exception = exc;
    assign data_resultRDY = (state == DONE);
endmodule
